// File: rtl/mac_pkg.sv
// Shared sizing for the MAC-path FIFO, its Round wrap-bit register and neighbours.
package mac_pkg;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = 3;

  typedef struct packed {
    logic [PTR_W-1:0] tp;
    logic [PTR_W-1:0] hp;
  } ptr_t;
endpackage

// File: rtl/ring_mem.sv
// Reset-free FIFO storage: one synchronous write port, one asynchronous read port.
module ring_mem
  import mac_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Four-entry FIFO pointer/handshake controller; the external Round bit
// disambiguates full from empty when TP == HP.
module fifo_ptr_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_valid,
  input  logic [DATA_W-1:0] rec_data,
  output logic              rec_ready,
  output logic              send_valid,
  output logic [DATA_W-1:0] send_data,
  input  logic              send_ready,
  input  logic              Round,
  output logic [PTR_W-1:0]  TP,
  output logic [PTR_W-1:0]  HP,
  output logic              Rec_Handshanking,
  output logic              Send_Handshaking,
  output logic [CNT_W-1:0]  count
);
  ptr_t             ptr_q;
  logic             ptr_eq, full, empty;
  logic [PTR_W-1:0] ptr_diff;

  assign ptr_eq   = (ptr_q.tp == ptr_q.hp);
  assign full     = ptr_eq &&  Round;
  assign empty    = ptr_eq && !Round;
  assign ptr_diff = ptr_q.tp - ptr_q.hp;

  assign rec_ready  = !rst && !full;
  assign send_valid = !rst && !empty;

  assign Rec_Handshanking = rec_valid && rec_ready;
  // During reset, fake a read at HP=3 so the Round register clears itself.
  assign Send_Handshaking = rst ? 1'b1 : (send_valid && send_ready);
  assign HP               = rst ? {PTR_W{1'b1}} : ptr_q.hp;
  assign TP               = ptr_q.tp;

  assign count = full ? CNT_W'(FIFO_DEPTH) : {1'b0, ptr_diff};

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      if (Rec_Handshanking) ptr_q.tp <= ptr_q.tp + 1'b1;
      if (Send_Handshaking) ptr_q.hp <= ptr_q.hp + 1'b1;
    end
  end

  ring_mem #(.DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .we    (Rec_Handshanking),
    .waddr (ptr_q.tp),
    .wdata (rec_data),
    .raddr (ptr_q.hp),
    .rdata (send_data)
  );
endmodule

// File: doc/fifo_ptr_ctrl.md
# fifo_ptr_ctrl

Four-entry circular FIFO controller and storage for the MAC datapath. Accepts words from an upstream valid/ready producer, presents them in order to a downstream valid/ready consumer, and generates the tail pointer (TP), head pointer (HP) and the two handshake strobes consumed by the Round wrap-bit register. It reads Round back to tell full from empty when TP equals HP.

## Interface
- DATA_W, 8, payload width in bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- rec_valid  in  1  upstream word available
- rec_data  in  DATA_W  upstream payload
- rec_ready  out  1  FIFO can accept (= !full)
- send_valid  out  1  FIFO holds a word (= !empty)
- send_data  out  DATA_W  word at HP, first-word fall-through
- send_ready  in  1  downstream accepts
- Round  in  1  wrap bit from Round register
- TP  out  2  tail (write) pointer
- HP  out  2  head (read) pointer
- Rec_Handshanking  out  1  write accepted this cycle
- Send_Handshaking  out  1  read accepted this cycle
- count  out  3  occupancy, 0..4

One clock, clk; reset rst is synchronous and active-high.

## Operation
- Depth fixed at 4; pointers are 2 bits, wrap 3→0 naturally.
- full = (TP == HP) && Round; empty = (TP == HP) && !Round.
- Rec_Handshanking = rec_valid && rec_ready; on it: mem[TP] <= rec_data, TP <= TP+1.
- Send_Handshaking = send_valid && send_ready; on it: HP <= HP+1.
- Simultaneous write and read allowed when neither full nor empty: both pointers advance, count unchanged.
- Write while full refused (rec_ready=0), even if a read happens the same cycle. Read while empty refused. Together these guarantee TP==3 write and HP==3 read never coincide on a wrap-bit conflict.
- count = full ? 4 : (TP − HP) mod 4, combinational.
- send_data = mem[HP] combinational; valid only while send_valid=1.
- Reset flush: the Round register has no reset. While rst=1 the block drives HP output = 2'b11, Send_Handshaking = 1, Rec_Handshanking = 0, so Round clears on every reset edge. In the same cycle TP and HP registers load 0. rec_ready and send_valid are 0 while rst=1.
- Storage contents are not reset.

## Timing
- Post-reset (first cycle after rst falls): TP=0, HP=0, Round=0, count=0, rec_ready=1, send_valid=0.
- Write-to-visible latency: 1 cycle. A word accepted at edge n shows on send_data with send_valid=1 after edge n.
- Round updates on the same edge as the wrapping pointer. full/empty are therefore consistent from the next cycle on, with no bubble.
- rec_ready and send_valid depend only on registered state, with no combinational path from rec_valid or send_ready.
- rst asserted mid-operation discards all contents on that edge, with the same results as the reset flush.

## Structure
- mac_pkg: FIFO_DEPTH=4, PTR_W=2, CNT_W=3 constants, shared with Round and its neighbours.
- Sub-module ring_mem: 4×DATA_W register array with a write port (we, waddr, wdata) and an async read port (raddr, rdata). Reset-free.
- Top holds the pointer registers, the handshake/flag logic and the reset-flush muxing.
- Benches instantiate fifo_ptr_ctrl together with the Round register.

## Test plan
- Reset: rst high for 2 cycles with Round preset to 1 → Round=0, TP=0, HP=0, count=0, rec_ready=1, send_valid=0 after release.
- Fill: write 0xA1,0xA2,0xA3,0xA4 back-to-back, send_ready=0 → on the 4th write TP wraps 3→0 and Round=1. Then full: rec_ready=0, count=4. A 5th word 0xA5 held with rec_valid=1 is not accepted and TP stays 0.
- Drain: from full, send_ready=1 for 4 cycles → send_data reads 0xA1..0xA4 in order, Round clears on the HP 3→0 step, empty, send_valid=0, count=0.
- Simultaneous: with count=2, rec_valid and send_ready both held high for 6 cycles → count stays 2, output order preserved, Round toggles each time the pointers pass 3.
- Full + read same cycle: at count=4, rec_valid=1 and send_ready=1 → read accepted, write refused, count=3. The write is accepted on the next cycle.
- Mid-op reset: at count=3, pulse rst for 1 cycle → count=0, send_valid=0, Round=0. The next written word 0x5C appears at send_data first.
